// File: rtl/tcdm_tx_if_pipe_pkg.sv
// Shared types and sizing helpers for the TCDM TX read pipe.
package mchan_tcdm_pkg;

    // Widest transfer ID a command entry can carry; narrower IDs are zero-extended.
    localparam int unsigned SID_MAX_W = 8;

    // One queued beat command: which transfer it belongs to and whether it closes it.
    typedef struct packed {
        logic [SID_MAX_W-1:0] sid;
        logic                 eop;
    } beat_cmd_t;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a read/write pointer into a depth-entry ring.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tcdm_tx_if_pipe_if.sv
// Bundle of beat, TX data, TCDM and status signals around the TX read pipe.
// Handshakes: a transfer happens on every cycle where valid (req) and ready
// (gnt) are both high; beat/TCDM requests may drop without a grant, while
// tx_data_req_o and tx_data_dat_o are held stable from assertion until granted.
// The slave modport is the pipe's own view; master is the environment's view.
interface tcdm_tx_if_pipe_if #(
    parameter int unsigned TRANS_SID_WIDTH = 2,
    parameter int unsigned TCDM_ADD_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH      = 32
);
    logic                       beat_eop_i;
    logic [TRANS_SID_WIDTH-1:0] beat_sid_i;
    logic [TCDM_ADD_WIDTH-1:0]  beat_add_i;
    logic [DATA_WIDTH/8-1:0]    beat_be_i;
    logic                       beat_we_ni;
    logic                       beat_req_i;
    logic                       beat_gnt_o;
    logic                       synch_req_o;
    logic [TRANS_SID_WIDTH-1:0] synch_sid_o;
    logic [DATA_WIDTH-1:0]      tx_data_dat_o;
    logic                       tx_data_req_o;
    logic                       tx_data_gnt_i;
    logic                       tcdm_req_o;
    logic [31:0]                tcdm_add_o;
    logic                       tcdm_we_o;
    logic [DATA_WIDTH-1:0]      tcdm_wdata_o;
    logic [DATA_WIDTH/8-1:0]    tcdm_be_o;
    logic                       tcdm_gnt_i;
    logic [DATA_WIDTH-1:0]      tcdm_r_rdata_i;
    logic                       tcdm_r_valid_i;
    logic                       err_o;

    modport slave (
        input  beat_eop_i, beat_sid_i, beat_add_i, beat_be_i, beat_we_ni, beat_req_i,
        input  tx_data_gnt_i, tcdm_gnt_i, tcdm_r_rdata_i, tcdm_r_valid_i,
        output beat_gnt_o, synch_req_o, synch_sid_o, tx_data_dat_o, tx_data_req_o,
        output tcdm_req_o, tcdm_add_o, tcdm_we_o, tcdm_wdata_o, tcdm_be_o, err_o
    );

    modport master (
        output beat_eop_i, beat_sid_i, beat_add_i, beat_be_i, beat_we_ni, beat_req_i,
        output tx_data_gnt_i, tcdm_gnt_i, tcdm_r_rdata_i, tcdm_r_valid_i,
        input  beat_gnt_o, synch_req_o, synch_sid_o, tx_data_dat_o, tx_data_req_o,
        input  tcdm_req_o, tcdm_add_o, tcdm_we_o, tcdm_wdata_o, tcdm_be_o, err_o
    );
endinterface

// File: rtl/tcdm_tx_if_pipe_fifo.sv
// Generic synchronous FIFO with full/empty/count; DEPTH must be a power of two.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module mchan_sync_fifo
    import mchan_tcdm_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (!do_push && do_pop) count_q <= count_q - CW'(1);
        end
    end

    // storage write; contents are meaningless once the pointers are reset
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/tcdm_tx_if_pipe.sv
// TCDM read-side TX pipe: issues credit-limited TCDM reads for TX beats,
// returns data in order with a zero-latency bypass, and pulses synch on the
// TX handshake of each end-of-packet beat.
module tcdm_tx_if_pipe
    import mchan_tcdm_pkg::*;
#(
    parameter int unsigned TRANS_SID_WIDTH = 2,
    parameter int unsigned TCDM_ADD_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned RESP_DEPTH      = 4
) (
    input logic              clk_i,
    input logic              rst_ni,
    tcdm_tx_if_pipe_if.slave bus
);
    localparam int unsigned CW = cnt_width(RESP_DEPTH);

    logic [CW-1:0]         in_flight_q, in_flight_d;
    logic                  err_q, err_d;
    logic                  tcdm_req, tcdm_hs;
    logic                  tx_req, tx_hs;
    logic [DATA_WIDTH-1:0] tx_dat;
    beat_cmd_t             cmd_in, cmd_head;
    logic                  cmd_full, cmd_empty;
    logic [CW-1:0]         cmd_count;
    logic [DATA_WIDTH-1:0] dat_head;
    logic                  dat_full, dat_empty;
    logic [CW-1:0]         dat_count;
    logic                  spurious, resp_ok, dat_push_req, dat_push, dat_pop, overflow;
    logic                  synch;
    logic                  cmd_unused;

    // Request side: only read beats are handled, and only while credit remains.
    assign tcdm_req = bus.beat_req_i & bus.beat_we_ni & (in_flight_q < CW'(RESP_DEPTH));
    assign tcdm_hs  = tcdm_req & bus.tcdm_gnt_i;
    assign cmd_in   = '{sid: SID_MAX_W'(bus.beat_sid_i), eop: bus.beat_eop_i};

    // Reads issued but not yet returned = in_flight minus what sits in the data FIFO;
    // a response with nothing outstanding is a protocol error and is dropped.
    assign spurious = bus.tcdm_r_valid_i & (in_flight_q == dat_count);
    assign resp_ok  = bus.tcdm_r_valid_i & ~spurious;

    // Head of the data FIFO has priority; an empty FIFO lets the response bypass.
    assign tx_req       = ~dat_empty | resp_ok;
    assign tx_dat       = dat_empty ? bus.tcdm_r_rdata_i : dat_head;
    assign tx_hs        = tx_req & bus.tx_data_gnt_i;
    assign dat_pop      = ~dat_empty & bus.tx_data_gnt_i;
    assign dat_push_req = resp_ok & ~(dat_empty & bus.tx_data_gnt_i);
    assign overflow     = dat_push_req & dat_full & ~dat_pop;
    assign dat_push     = dat_push_req & ~overflow;

    assign synch      = tx_hs & ~cmd_empty & cmd_head.eop;
    assign cmd_unused = ^{cmd_full, cmd_count, cmd_head.sid};

    mchan_sync_fifo #(
        .WIDTH ($bits(beat_cmd_t)),
        .DEPTH (RESP_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (tcdm_hs),
        .pop_i   (tx_hs),
        .data_i  (cmd_in),
        .data_o  (cmd_head),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .count_o (cmd_count)
    );

    mchan_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RESP_DEPTH)
    ) u_dat_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (dat_push),
        .pop_i   (dat_pop),
        .data_i  (bus.tcdm_r_rdata_i),
        .data_o  (dat_head),
        .full_o  (dat_full),
        .empty_o (dat_empty),
        .count_o (dat_count)
    );

    // credit counter and sticky error next-state
    always_comb begin
        in_flight_d = in_flight_q;
        err_d       = err_q | spurious | overflow;
        if (tcdm_hs && !tx_hs)      in_flight_d = in_flight_q + CW'(1);
        else if (!tcdm_hs && tx_hs) in_flight_d = in_flight_q - CW'(1);
    end

    // credit counter and error flag registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            in_flight_q <= '0;
            err_q       <= 1'b0;
        end else begin
            in_flight_q <= in_flight_d;
            err_q       <= err_d;
        end
    end

    // Outputs are forced low while reset is asserted.
    assign bus.tcdm_req_o    = rst_ni & tcdm_req;
    assign bus.beat_gnt_o    = rst_ni & tcdm_hs;
    assign bus.tcdm_add_o    = rst_ni ? 32'(bus.beat_add_i) : '0;
    assign bus.tcdm_we_o     = rst_ni & bus.beat_we_ni;
    assign bus.tcdm_be_o     = rst_ni ? bus.beat_be_i : '0;
    assign bus.tcdm_wdata_o  = '0;
    assign bus.tx_data_req_o = rst_ni & tx_req;
    assign bus.tx_data_dat_o = rst_ni ? tx_dat : '0;
    assign bus.synch_req_o   = rst_ni & synch;
    assign bus.synch_sid_o   = (rst_ni && synch) ? cmd_head.sid[TRANS_SID_WIDTH-1:0] : '0;
    assign bus.err_o         = err_q;

endmodule
